// File: rtl/pipe_pkg.sv
// Shared pipeline-control types: register select codes, hazard FSM states and
// the bundled per-cycle control word driven by hazard_ctrl.
package pipe_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    SEL_LOAD = 2'b00,
    SEL_HOLD = 2'b01,
    SEL_CLR  = 2'b11
  } sel_e;

  typedef enum logic [1:0] {
    RUN,
    LD_STALL,
    MEM_WAIT
  } hz_state_e;

  typedef struct packed {
    logic pc_en;
    sel_e if_id;
    sel_e id_ex;
    sel_e ex_mem;
    sel_e mem_wb;
    logic mem_err;
  } hz_out_t;

  localparam hz_out_t OUT_RUN   = '{1'b1, SEL_LOAD, SEL_LOAD, SEL_LOAD, SEL_LOAD, 1'b0};
  localparam hz_out_t OUT_MWAIT = '{1'b0, SEL_HOLD, SEL_HOLD, SEL_HOLD, SEL_CLR,  1'b0};
  localparam hz_out_t OUT_FLUSH = '{1'b1, SEL_CLR,  SEL_CLR,  SEL_LOAD, SEL_LOAD, 1'b0};
  localparam hz_out_t OUT_LDUSE = '{1'b0, SEL_HOLD, SEL_CLR,  SEL_LOAD, SEL_LOAD, 1'b0};
  localparam hz_out_t OUT_TMO   = '{1'b1, SEL_LOAD, SEL_LOAD, SEL_LOAD, SEL_CLR,  1'b1};
  localparam hz_out_t OUT_RST   = '{1'b0, SEL_CLR,  SEL_CLR,  SEL_CLR,  SEL_CLR,  1'b0};

endpackage

// File: rtl/hazard_wait_timer.sv
// Saturating load/clear/increment wait counter with a terminal-count flag,
// used to bound data-memory waits.
module hazard_wait_timer #(
  parameter int unsigned MAX_COUNT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam int unsigned W = $clog2(MAX_COUNT + 1);

  logic [W-1:0] cnt_q;

  assign tc_o = (cnt_q == W'(MAX_COUNT));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= W'(1);
    end else if (inc_i && !tc_o) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes and bounded
// data-memory waits. Optional perf counters under HAZARD_PERF_CNT_EN.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned LOAD_USE_CYCLES    = 1,
  parameter int unsigned MEM_TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
  input  logic                  id_rs1_used_i,
  input  logic                  id_rs2_used_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
  input  logic                  ex_is_load_i,
  input  logic                  ex_br_taken_i,
  input  logic                  mem_req_i,
  input  logic                  mem_ack_i,
  output logic                  pc_en_o,
  output logic [1:0]            if_id_sel_o,
  output logic [1:0]            id_ex_sel_o,
  output logic [1:0]            ex_mem_sel_o,
  output logic [1:0]            mem_wb_sel_o,
  output logic                  mem_err_o,
  output logic [31:0]           stall_cnt_o,
  output logic [31:0]           flush_cnt_o
);

  hz_state_e state_q, state_d;
  logic [1:0] ld_cnt_q, ld_cnt_d;
  hz_out_t    out;
  logic       run_rules;
  logic       mem_stall, load_use;
  logic       tmr_load, tmr_clr, tmr_inc, tmr_tc;

  assign mem_stall = mem_req_i && !mem_ack_i;
  assign load_use  = ex_is_load_i && (ex_rd_addr_i != '0) &&
                     ((id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                      (id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i)));

  hazard_wait_timer #(
    .MAX_COUNT(MEM_TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (tmr_load),
    .clr_i  (tmr_clr),
    .inc_i  (tmr_inc),
    .tc_o   (tmr_tc)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= RUN;
      ld_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
    end
  end

  // A memory ack in MEM_WAIT releases into the normal RUN priority chain in the
  // same cycle, so a branch held in EX during the wait flushes on release.
  always_comb begin
    out       = OUT_RUN;
    state_d   = state_q;
    ld_cnt_d  = ld_cnt_q;
    run_rules = 1'b0;
    tmr_load  = 1'b0;
    tmr_clr   = 1'b0;
    tmr_inc   = 1'b0;

    case (state_q)
      RUN: run_rules = 1'b1;
      LD_STALL: begin
        if (mem_stall) begin
          out = OUT_MWAIT;
        end else begin
          out      = OUT_LDUSE;
          ld_cnt_d = ld_cnt_q - 2'd1;
          if (ld_cnt_q == 2'd1) state_d = RUN;
        end
      end
      MEM_WAIT: begin
        if (mem_ack_i) begin
          tmr_clr   = 1'b1;
          state_d   = RUN;
          run_rules = 1'b1;
        end else if (tmr_tc) begin
          out     = OUT_TMO;
          tmr_clr = 1'b1;
          state_d = RUN;
        end else begin
          out     = OUT_MWAIT;
          tmr_inc = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    if (run_rules) begin
      if (mem_stall) begin
        out      = OUT_MWAIT;
        tmr_load = 1'b1;
        state_d  = MEM_WAIT;
      end else if (ex_br_taken_i) begin
        out = OUT_FLUSH;
      end else if (load_use) begin
        out = OUT_LDUSE;
        if (LOAD_USE_CYCLES > 1) begin
          ld_cnt_d = 2'(LOAD_USE_CYCLES - 1);
          state_d  = LD_STALL;
        end
      end
    end

    if (!rst_ni) out = OUT_RST;
  end

  assign pc_en_o      = out.pc_en;
  assign if_id_sel_o  = out.if_id;
  assign id_ex_sel_o  = out.id_ex;
  assign ex_mem_sel_o = out.ex_mem;
  assign mem_wb_sel_o = out.mem_wb;
  assign mem_err_o    = out.mem_err;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  // Only a flush drives IF/ID to CLEAR while the PC advances.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!out.pc_en && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (out.pc_en && (out.if_id == SEL_CLR) && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two instances (1 and 2 load-use bubbles),
// both with a 4-cycle memory timeout, driven by the same stimulus.
module tb_hazard_ctrl;

  localparam logic [9:0] V_RUN = 10'b1_00_00_00_00_0;
  localparam logic [9:0] V_LU  = 10'b0_01_11_00_00_0;
  localparam logic [9:0] V_MW  = 10'b0_01_01_01_11_0;
  localparam logic [9:0] V_FL  = 10'b1_11_11_00_00_0;
  localparam logic [9:0] V_TO  = 10'b1_00_00_00_11_1;
  localparam logic [9:0] V_RST = 10'b0_11_11_11_11_0;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic       rst;
    logic [9:0] ea;
    logic [9:0] eb;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic u1 = 1'b0, u2 = 1'b0, ld = 1'b0, br = 1'b0, req = 1'b0, ack = 1'b0;

  logic pc_a, err_a, pc_b, err_b;
  logic [1:0] ifid_a, idex_a, exmem_a, memwb_a, ifid_b, idex_b, exmem_b, memwb_b;
  logic [31:0] sc_a, fc_a, sc_b, fc_b;

  sb_t         sb_q[$];
  sb_t         e;
  logic [31:0] es_a = '0, ef_a = '0, es_b = '0, ef_b = '0;
  int          n_cmp = 0, n_err = 0, cyc = 0;
  string       cur_test = "init";

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_USE_CYCLES(1), .MEM_TIMEOUT_CYCLES(4)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2), .id_rs1_used_i(u1), .id_rs2_used_i(u2),
    .ex_rd_addr_i(rd), .ex_is_load_i(ld), .ex_br_taken_i(br),
    .mem_req_i(req), .mem_ack_i(ack),
    .pc_en_o(pc_a), .if_id_sel_o(ifid_a), .id_ex_sel_o(idex_a),
    .ex_mem_sel_o(exmem_a), .mem_wb_sel_o(memwb_a), .mem_err_o(err_a),
    .stall_cnt_o(sc_a), .flush_cnt_o(fc_a)
  );

  hazard_ctrl #(.LOAD_USE_CYCLES(2), .MEM_TIMEOUT_CYCLES(4)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2), .id_rs1_used_i(u1), .id_rs2_used_i(u2),
    .ex_rd_addr_i(rd), .ex_is_load_i(ld), .ex_br_taken_i(br),
    .mem_req_i(req), .mem_ack_i(ack),
    .pc_en_o(pc_b), .if_id_sel_o(ifid_b), .id_ex_sel_o(idex_b),
    .ex_mem_sel_o(exmem_b), .mem_wb_sel_o(memwb_b), .mem_err_o(err_b),
    .stall_cnt_o(sc_b), .flush_cnt_o(fc_b)
  );

  // Drive one cycle of inputs at posedge+1, queue the expected outputs, then
  // advance to the next posedge+1. The monitor pops at the negedge in between.
  task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic f1,
                       input logic f2, input logic [4:0] d, input logic l, input logic b,
                       input logic rq, input logic ak, input logic [9:0] ea,
                       input logic [9:0] eb);
    rs1 = a1; rs2 = a2; u1 = f1; u2 = f2; rd = d; ld = l; br = b; req = rq; ack = ak;
    sb_q.push_back('{rst: !rst_n, ea: ea, eb: eb});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [9:0] ea, input logic [9:0] eb);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ea, eb);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      cyc++;
      if (e.rst) begin
        es_a = '0; ef_a = '0; es_b = '0; ef_b = '0;
      end
      n_cmp += 6;
      if ({pc_a, ifid_a, idex_a, exmem_a, memwb_a, err_a} !== e.ea) begin
        n_err++;
        $display("FAIL %s cyc%0d outs_a: got %b want %b", cur_test, cyc,
                 {pc_a, ifid_a, idex_a, exmem_a, memwb_a, err_a}, e.ea);
      end
      if ({pc_b, ifid_b, idex_b, exmem_b, memwb_b, err_b} !== e.eb) begin
        n_err++;
        $display("FAIL %s cyc%0d outs_b: got %b want %b", cur_test, cyc,
                 {pc_b, ifid_b, idex_b, exmem_b, memwb_b, err_b}, e.eb);
      end
      if (sc_a !== (PERF ? es_a : 32'd0)) begin
        n_err++;
        $display("FAIL %s cyc%0d stall_cnt_a: got %0d want %0d", cur_test, cyc, sc_a, PERF ? es_a : 32'd0);
      end
      if (fc_a !== (PERF ? ef_a : 32'd0)) begin
        n_err++;
        $display("FAIL %s cyc%0d flush_cnt_a: got %0d want %0d", cur_test, cyc, fc_a, PERF ? ef_a : 32'd0);
      end
      if (sc_b !== (PERF ? es_b : 32'd0)) begin
        n_err++;
        $display("FAIL %s cyc%0d stall_cnt_b: got %0d want %0d", cur_test, cyc, sc_b, PERF ? es_b : 32'd0);
      end
      if (fc_b !== (PERF ? ef_b : 32'd0)) begin
        n_err++;
        $display("FAIL %s cyc%0d flush_cnt_b: got %0d want %0d", cur_test, cyc, fc_b, PERF ? ef_b : 32'd0);
      end
      if (!e.rst) begin
        if (!e.ea[9]) es_a = es_a + 32'd1;
        if (e.ea[9:7] == 3'b111) ef_a = ef_a + 32'd1;
        if (!e.eb[9]) es_b = es_b + 32'd1;
        if (e.eb[9:7] == 3'b111) ef_b = ef_b + 32'd1;
      end
    end
  end

  task automatic test_reset();
    cur_test = "reset";
    idle(V_RST, V_RST);
    idle(V_RST, V_RST);
    rst_n = 1'b1;
    idle(V_RUN, V_RUN);
  endtask

  task automatic test_load_use();
    cur_test = "load_use";
    drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, V_LU, V_LU);
    idle(V_RUN, V_LU);
    idle(V_RUN, V_RUN);
    drive(5'd0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, V_LU, V_LU);
    idle(V_RUN, V_LU);
    drive(5'd0, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, V_RUN, V_RUN);
    drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, V_RUN, V_RUN);
    drive(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, V_RUN, V_RUN);
    drive(5'd4, 5'd6, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, V_RUN, V_RUN);
  endtask

  task automatic test_branch();
    cur_test = "branch";
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, V_FL, V_FL);
    drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, V_FL, V_FL);
    idle(V_RUN, V_RUN);
  endtask

  task automatic test_mem_wait();
    cur_test = "mem_wait";
    for (int i = 0; i < 3; i++)
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, V_MW, V_MW);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, V_RUN, V_RUN);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, V_RUN, V_RUN);
    drive(5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, V_LU, V_LU);
    idle(V_RUN, V_LU);
  endtask

  task automatic test_timeout();
    cur_test = "timeout";
    for (int i = 0; i < 4; i++)
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, V_MW, V_MW);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, V_TO, V_TO);
    idle(V_RUN, V_RUN);
    idle(V_RUN, V_RUN);
  endtask

  task automatic test_branch_in_wait();
    cur_test = "branch_in_wait";
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, V_MW, V_MW);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, V_MW, V_MW);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, V_FL, V_FL);
    idle(V_RUN, V_RUN);
  endtask

  task automatic test_mem_in_ld_stall();
    cur_test = "mem_in_ld_stall";
    drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, V_LU, V_LU);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, V_MW, V_MW);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, V_RUN, V_LU);
    idle(V_RUN, V_RUN);
  endtask

  task automatic test_reset_mid_wait();
    cur_test = "reset_mid_wait";
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, V_MW, V_MW);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, V_MW, V_MW);
    rst_n = 1'b0;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, V_RST, V_RST);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) idle(V_RUN, V_RUN);
  endtask

  task automatic test_back_to_back();
    cur_test = "back_to_back";
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, V_MW, V_MW);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, V_RUN, V_RUN);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, V_MW, V_MW);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, V_RUN, V_RUN);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, V_FL, V_FL);
    drive(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, V_LU, V_LU);
    idle(V_RUN, V_LU);
    idle(V_RUN, V_RUN);
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_branch_in_wait();
    test_mem_in_ld_stall();
    test_reset_mid_wait();
    test_back_to_back();
    #5;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, bench did not finish");
    $fatal(1);
  end

endmodule
